// File: rtl/fifo_pack_sync.sv
// Width-converting FIFO: packs RATIO narrow words LSB-first into one wide word, stores DEPTH wide words.
// Latency: word readable the cycle after its last lane is written; q one cycle after rdreq (or show-ahead). Backpressure: full/overflow on write, empty/underflow on read.
module fifo_pack_sync #(
    parameter int IN_W       = 16,
    parameter int RATIO_LOG2 = 1,
    parameter int AW         = 9,
    parameter int SHOWAHEAD  = 0,
    localparam int RATIO     = 1 << RATIO_LOG2,
    localparam int OUT_W     = IN_W * RATIO,
    localparam int DEPTH     = 1 << AW
) (
    input  logic                      clk,
    input  logic                      aclr,
    input  logic [IN_W-1:0]           data,
    input  logic                      wrreq,
    input  logic                      rdreq,
    input  logic                      flush,
    output logic [OUT_W-1:0]          q,
    output logic                      empty,
    output logic                      full,
    output logic [AW+RATIO_LOG2:0]    wrusedw,
    output logic [AW:0]               rdusedw,
    output logic                      overflow,
    output logic                      underflow
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [OUT_W-1:0]      r_mem [DEPTH];
    logic [OUT_W-IN_W-1:0] r_pack;
    logic [RATIO_LOG2-1:0] r_lane;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_cnt;
    logic                  r_ovf;
    logic                  r_unf;

    logic w_last;
    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_commit;

    assign w_last   = &r_lane;
    assign w_full   = (r_cnt == DEPTH_CNT) && w_last;
    assign w_empty  = (r_cnt == '0);
    assign w_wr_acc = wrreq && !w_full;
    assign w_rd_acc = rdreq && !w_empty;
    assign w_commit = w_wr_acc && w_last;

    always_ff @(posedge clk) begin
        if (!aclr) begin
            r_pack   <= '0;
            r_lane   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (flush) begin
            r_pack   <= '0;
            r_lane   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_ovf <= wrreq && w_full;
            r_unf <= rdreq && w_empty;
            if (w_wr_acc) begin
                if (w_last) begin
                    r_lane   <= '0;
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end else begin
                    r_lane <= r_lane + 1'b1;
                    for (int k = 0; k < RATIO - 1; k++) begin
                        if (r_lane == RATIO_LOG2'(k))
                            r_pack[k*IN_W +: IN_W] <= data;
                    end
                end
            end
            if (w_rd_acc)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            // A commit and a pop in the same cycle cancel out.
            case ({w_commit, w_rd_acc})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Last lane bypasses the packer and lands in RAM together with the lower slices.
    always_ff @(posedge clk) begin
        if (aclr && !flush && w_commit)
            r_mem[r_wr_ptr] <= {data, r_pack};
    end

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            assign q = r_mem[r_rd_ptr];
        end else begin : g_registered
            logic [OUT_W-1:0] r_q;
            always_ff @(posedge clk) begin
                if (!aclr)
                    r_q <= '0;
                else if (!flush && w_rd_acc)
                    r_q <= r_mem[r_rd_ptr];
            end
            assign q = r_q;
        end
    endgenerate

    assign empty     = w_empty;
    assign full      = w_full;
    assign wrusedw   = {r_cnt, r_lane};
    assign rdusedw   = r_cnt;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule

// File: tb/tb_fifo_pack_sync.sv
// Bench: registered and show-ahead instances share stimulus; a queue-based model supplies expectations.
module tb_fifo_pack_sync;
    localparam int IN_W  = 16;
    localparam int RL    = 1;
    localparam int AW    = 3;
    localparam int RATIO = 1 << RL;
    localparam int DEPTH = 1 << AW;
    localparam int OUT_W = IN_W * RATIO;

    logic clk = 1'b0;
    logic aclr, wrreq, rdreq, flush;
    logic [IN_W-1:0] data;
    logic [OUT_W-1:0] q0, q1;
    logic e0, e1, f0, f1, ov0, ov1, un0, un1;
    logic [AW+RL:0] wu0, wu1;
    logic [AW:0] ru0, ru1;

    always #5 clk = ~clk;

    fifo_pack_sync #(.IN_W(IN_W), .RATIO_LOG2(RL), .AW(AW), .SHOWAHEAD(0)) u_reg (
        .clk(clk), .aclr(aclr), .data(data), .wrreq(wrreq), .rdreq(rdreq), .flush(flush),
        .q(q0), .empty(e0), .full(f0), .wrusedw(wu0), .rdusedw(ru0),
        .overflow(ov0), .underflow(un0));

    fifo_pack_sync #(.IN_W(IN_W), .RATIO_LOG2(RL), .AW(AW), .SHOWAHEAD(1)) u_sa (
        .clk(clk), .aclr(aclr), .data(data), .wrreq(wrreq), .rdreq(rdreq), .flush(flush),
        .q(q1), .empty(e1), .full(f1), .wrusedw(wu1), .rdusedw(ru1),
        .overflow(ov1), .underflow(un1));

    logic [OUT_W-1:0] mq[$];
    logic [IN_W-1:0]  pend[$];
    logic [OUT_W-1:0] exp_q0;
    bit exp_ov, exp_un;
    int checks, failures;
    int words_out;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst_n, input bit wr, input bit rd, input bit fl,
                              input logic [IN_W-1:0] d);
        bit m_full, m_empty;
        logic [OUT_W-1:0] w;
        if (!rst_n) begin
            mq.delete(); pend.delete();
            exp_q0 = '0; exp_ov = 0; exp_un = 0;
        end else if (fl) begin
            mq.delete(); pend.delete();
            exp_ov = 0; exp_un = 0;
        end else begin
            m_full  = (mq.size() == DEPTH) && (pend.size() == RATIO - 1);
            m_empty = (mq.size() == 0);
            exp_ov  = wr && m_full;
            exp_un  = rd && m_empty;
            if (rd && !m_empty) begin
                exp_q0 = mq.pop_front();
                words_out++;
            end
            if (wr && !m_full) begin
                pend.push_back(d);
                if (pend.size() == RATIO) begin
                    w = '0;
                    for (int i = RATIO - 1; i >= 0; i--) w = (w << IN_W) | OUT_W'(pend[i]);
                    mq.push_back(w);
                    pend.delete();
                end
            end
        end
    endtask

    task automatic compare();
        int exp_wu;
        bit m_full;
        exp_wu = mq.size() * RATIO + pend.size();
        m_full = (mq.size() == DEPTH) && (pend.size() == RATIO - 1);
        chk("rdusedw", ru0, mq.size());
        chk("wrusedw", wu0, exp_wu);
        chk("empty", e0, mq.size() == 0);
        chk("full", f0, m_full);
        chk("overflow", ov0, exp_ov);
        chk("underflow", un0, exp_un);
        chk("q_reg", q0, exp_q0);
        chk("cnt_bound", ru0 <= DEPTH, 1);
        chk("sa_status", {ov1, un1, f1, e1, wu1, ru1},
            {exp_ov, exp_un, m_full, mq.size() == 0, (AW+RL+1)'(exp_wu), (AW+1)'(mq.size())});
        if (mq.size() != 0) chk("sa_q_head", q1, mq[0]);
    endtask

    task automatic step(input bit rst_n, input bit wr, input bit rd, input bit fl,
                        input logic [IN_W-1:0] d);
        aclr = rst_n; wrreq = wr; rdreq = rd; flush = fl; data = d;
        @(posedge clk);
        model_edge(rst_n, wr, rd, fl, d);
        #1;
        aclr = 1'b1; wrreq = 1'b0; rdreq = 1'b0; flush = 1'b0;
        compare();
    endtask

    logic [OUT_W-1:0] saved_q;

    initial begin
        checks = 0; failures = 0; words_out = 0;
        exp_q0 = '0; exp_ov = 0; exp_un = 0;
        aclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0; flush = 1'b0; data = '0;

        step(0, 1, 1, 1, 16'hFFFF);
        step(0, 0, 0, 0, 16'h0);
        chk("rst_q", q0, 0);
        chk("rst_empty", e0, 1);

        // Two-word pack and registered read
        step(1, 1, 0, 0, 16'h1111);
        step(1, 1, 0, 0, 16'h2222);
        chk("t1_rdusedw", ru0, 1);
        chk("t1_wrusedw", wu0, 2);
        step(1, 0, 1, 0, 16'h0);
        chk("t1_q", q0, 32'h2222_1111);

        // Partial word stays invisible
        step(1, 1, 0, 0, 16'h000A);
        step(1, 1, 0, 0, 16'h000B);
        step(1, 1, 0, 0, 16'h000C);
        chk("t2_wrusedw", wu0, 3);
        step(1, 0, 1, 0, 16'h0);
        chk("t2_q", q0, 32'h000B_000A);
        chk("t2_empty", e0, 1);

        // Underflow pulse
        step(1, 0, 1, 0, 16'h0);
        chk("t4_underflow", un0, 1);
        chk("t4_q_held", q0, 32'h000B_000A);
        step(1, 0, 0, 0, 16'h0);
        chk("t4_underflow_pulse", un0, 0);

        // Fill to full, then overflow
        step(1, 0, 0, 1, 16'h0);
        for (int i = 0; i < DEPTH * RATIO + RATIO - 1; i++)
            step(1, 1, 0, 0, 16'($urandom));
        chk("t3_full", f0, 1);
        step(1, 1, 0, 0, 16'hDEAD);
        chk("t3_overflow", ov0, 1);
        chk("t3_wrusedw", wu0, DEPTH * RATIO + RATIO - 1);
        step(1, 0, 0, 0, 16'h0);
        chk("t3_overflow_pulse", ov0, 0);
        step(1, 1, 1, 0, 16'hBEEF);
        chk("t3_overflow_rw", ov0, 1);

        // Flush with data and a write pending
        saved_q = exp_q0;
        step(1, 1, 1, 1, 16'h5555);
        chk("t6_empty", e0, 1);
        chk("t6_wrusedw", wu0, 0);
        chk("t6_no_ovf", ov0, 0);
        chk("t6_no_unf", un0, 0);
        chk("t6_q_kept", q0, saved_q);

        // Randomised streaming with alternating fill/drain bias
        words_out = 0;
        for (int i = 0; i < 1500; i++) begin
            bit wr, rd, fl, rst;
            int rd_pct;
            rd_pct = ((i / 120) % 2 == 0) ? 25 : 70;
            wr  = ($urandom_range(99) < 60);
            rd  = ($urandom_range(99) < rd_pct);
            fl  = ($urandom_range(299) == 0);
            rst = ($urandom_range(699) == 0);
            step(!rst, wr, rd, fl, 16'($urandom));
        end
        chk("t5_wrapped", words_out > 3 * DEPTH, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
